// File: rtl/swu_rom_fetch_if.sv
// Bus bundle between the fetch sequencer, the swu_rom_* read port and the SWU datapath stream.
// master = sequencer side; slave = ROM/datapath side.
interface swu_rom_fetch_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output rom_en, rom_addr, out_valid, out_data, out_idx, out_last,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_en, rom_addr, out_valid, out_data, out_idx, out_last,
        output rom_data, out_ready
    );
endinterface

// File: rtl/swu_rom_fetch.sv
// Walks ROM addresses 0..DEPTH-1 and streams the words through a 2-entry skid FIFO.
// Define SWU_FETCH_CKSUM_EN to build the running XOR checksum on cksum (tied to 0 otherwise).
module swu_rom_fetch #(
    parameter int DEPTH  = 29,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cksum,
    swu_rom_fetch_if.master   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_P  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_next;
    logic [ADDR_W:0]   ptr, ptr_next;
    logic [ADDR_W-1:0] addr_q;
    logic              inflight;
    logic [1:0]        count;
    logic              rd_ptr, wr_ptr;
    logic [DATA_W-1:0] fifo_data [2];
    logic [ADDR_W-1:0] fifo_idx  [2];
    logic              done_q, done_next;
    logic              pop, kill, start_acc;
    logic [2:0]        occ;

    assign pop       = bus.out_valid & bus.out_ready;
    assign kill      = abort & (state != IDLE);
    assign start_acc = (state == IDLE) & start & ~abort;
    // Slots that will be occupied after this cycle's pop; issuing needs one free.
    assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = fifo_data[rd_ptr];
    assign bus.out_idx   = fifo_idx[rd_ptr];
    assign bus.out_last  = bus.out_valid & (bus.out_idx == LAST_IDX);
    assign busy          = (state != IDLE);
    assign done          = done_q;

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        done_next    = 1'b0;
        bus.rom_en   = 1'b0;
        bus.rom_addr = addr_q;
        if (state == FETCH && ptr < DEPTH_P && occ < 3'd2) begin
            bus.rom_en   = 1'b1;
            bus.rom_addr = ptr[ADDR_W-1:0];
            ptr_next     = ptr + 1'b1;
            if (ptr_next == DEPTH_P) state_next = DRAIN;
        end
        case (state)
            IDLE: begin
                if (start_acc) begin
                    state_next = FETCH;
                    ptr_next   = '0;
                end
            end
            DRAIN: begin
                if (pop && bus.out_idx == LAST_IDX) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: ;
        endcase
        if (kill) begin
            state_next = IDLE;
            done_next  = 1'b0;
        end
    end

    // addr_q doubles as the index of the word in flight, since it always holds the last issued address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            addr_q   <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_idx[i]  <= '0;
            end
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            addr_q <= bus.rom_addr;
            done_q <= done_next;
            if (kill) begin
                inflight <= 1'b0;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                inflight <= bus.rom_en;
                if (inflight) begin
                    fifo_data[wr_ptr] <= bus.rom_data;
                    fifo_idx[wr_ptr]  <= addr_q;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, inflight} - {1'b0, pop};
            end
        end
    end

`ifdef SWU_FETCH_CKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    // Accumulates every accepted word; an abort simply stops the updates, freezing the partial value.
    always_ff @(posedge clk) begin
        if (rst)            cksum_q <= '0;
        else if (start_acc) cksum_q <= '0;
        else if (pop)       cksum_q <= cksum_q ^ bus.out_data;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif
endmodule

// File: tb/tb_swu_rom_fetch.sv
// Self-checking bench for swu_rom_fetch: behavioural stream model plus directed timing literals.
module tb_swu_rom_fetch;
    localparam int DEPTH  = 29;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] cksum;

    swu_rom_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    swu_rom_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .cksum (cksum),
        .bus   (bus)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          base = 0;
    logic [31:0] salt = 32'h0;

    bit          m_active = 1'b0;
    bit          m_done_exp = 1'b0;
    bit          prev_stall = 1'b0;
    int          m_next_idx = 0;
    int          m_issue = 0;
    logic [31:0] m_cksum = 32'h0;

    int          pass_words, done_cnt;
    int          first_en, last_en, first_valid, last_valid, done_rel;
    logic [31:0] last_data, done_cksum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input int a);
        return (32'(a) * 32'h01010101) ^ salt;
    endfunction

    // Registered ROM: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_word(int'(bus.rom_addr));
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_out_valid"}, bus.out_valid, 0);
        check_output({tag, "_rom_en"}, bus.rom_en, 0);
        check_output({tag, "_rom_addr"}, bus.rom_addr, 0);
        check_output({tag, "_out_data"}, bus.out_data, 0);
        check_output({tag, "_out_idx"}, bus.out_idx, 0);
        check_output({tag, "_out_last"}, bus.out_last, 0);
        check_output({tag, "_cksum"}, cksum, 0);
    endtask

    task automatic apply_stimulus(input int r, input bit st, input bit ab, input bit rdy, input bit rs);
        @(posedge clk);
        #1;
        if (r == 0) base = cyc;
        start         = st;
        abort         = ab;
        bus.out_ready = rdy;
        rst           = rs;
    endtask

    // Compare process: the model is a pass-level view (next index expected, words accepted, pass active).
    always @(negedge clk) begin : monitor
        int rel;
        bit hs;
        rel = cyc - base;
        hs  = bus.out_valid & bus.out_ready;
        if (!rst) begin
            check_output("busy", busy, m_active);
            check_output("done", done, m_done_exp);
            check_output("fifo_count_le2", dut.count <= 2'd2, 1);
            if (bus.rom_en) begin
                check_output("rom_en_in_pass", m_active, 1);
                check_output("rom_addr", bus.rom_addr, m_issue);
            end
            if (bus.out_valid) begin
                check_output("valid_in_pass", m_active, 1);
                check_output("out_idx", bus.out_idx, m_next_idx);
                check_output("out_data", bus.out_data, rom_word(m_next_idx));
                check_output("out_last", bus.out_last, m_next_idx == DEPTH - 1);
            end else begin
                check_output("out_last_idle", bus.out_last, 0);
                if (prev_stall) check_output("valid_held", bus.out_valid, 1);
            end
`ifdef SWU_FETCH_CKSUM_EN
            check_output("cksum", cksum, m_cksum);
`else
            check_output("cksum_off", cksum, 0);
`endif
        end

        if (bus.rom_en) begin
            if (first_en < 0) first_en = rel;
            last_en = rel;
        end
        if (bus.out_valid && first_valid < 0) first_valid = rel;
        if (bus.out_last) begin
            last_valid = rel;
            last_data  = bus.out_data;
        end
        if (done) begin
            done_cnt++;
            if (done_rel < 0) begin
                done_rel   = rel;
                done_cksum = cksum;
            end
        end

        if (rst) begin
            m_active   = 1'b0;
            m_done_exp = 1'b0;
            prev_stall = 1'b0;
            m_next_idx = 0;
            m_issue    = 0;
            m_cksum    = 32'h0;
        end else begin
            m_done_exp = 1'b0;
            prev_stall = bus.out_valid & ~bus.out_ready & ~(abort & m_active);
            if (bus.rom_en) m_issue++;
            if (m_active) begin
                if (hs) begin
                    m_cksum ^= rom_word(m_next_idx);
                    pass_words++;
                end
                if (abort) begin
                    m_active = 1'b0;
                end else if (hs) begin
                    if (m_next_idx == DEPTH - 1) begin
                        m_active   = 1'b0;
                        m_done_exp = 1'b1;
                    end
                    m_next_idx++;
                end
            end else if (start && !abort) begin
                m_active   = 1'b1;
                m_next_idx = 0;
                m_issue    = 0;
                m_cksum    = 32'h0;
            end
        end
    end

    // mode: 0 ready held high, 1 stall cycles 3-12, 2 toggle 1,0,1,0..., 3 random ready.
    task automatic run_test(input int mode, input int abort_at, input int rst_at, input int stray0, input int stray1);
        bit expect_done;
        int stop_at;
        bit rdy;
        expect_done = (abort_at < 0 && rst_at < 0);
        first_en = -1; last_en = -1; first_valid = -1; last_valid = -1; done_rel = -1;
        pass_words = 0; done_cnt = 0;
        stop_at = expect_done ? 400 : ((abort_at >= 0 ? abort_at : rst_at) + 4);
        for (int r = 0; r <= stop_at; r++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(r >= 3 && r <= 12);
                2:       rdy = (r % 2 == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            apply_stimulus(r, r == 0 || r == stray0 || r == stray1, r == abort_at, rdy, r == rst_at);
            #1;
            if (mode == 1 && r == 12) begin
                check_output("stall_rom_en", bus.rom_en, 0);
                check_output("stall_valid", bus.out_valid, 1);
                check_output("stall_idx", bus.out_idx, 0);
                check_output("stall_data", bus.out_data, 32'h00000000);
            end
            if (abort_at >= 0 && r == abort_at + 1) begin
                check_output("abort_busy", busy, 0);
                check_output("abort_valid", bus.out_valid, 0);
            end
            if (rst_at >= 0 && r == rst_at + 1) check_all_zero("rst_mid");
            if (expect_done && done_rel >= 0 && r > done_rel + 1) break;
        end
        if (expect_done) begin
            check_output("done_before_timeout", done_rel >= 0, 1);
            check_output("words_per_pass", pass_words, DEPTH);
            check_output("done_pulses", done_cnt, 1);
        end else begin
            check_output("no_done", done_cnt, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b1;
        repeat (3) apply_stimulus(-1, 0, 0, 1, 1);
        apply_stimulus(-1, 0, 0, 1, 0);
        check_all_zero("reset");

        $display("[TB] basic pass");
        run_test(0, -1, -1, -1, -1);
        check_output("t1_first_en", first_en, 1);
        check_output("t1_last_en", last_en, 29);
        check_output("t1_first_valid", first_valid, 3);
        check_output("t1_last_valid", last_valid, 31);
        check_output("t1_last_data", last_data, 32'h1C1C1C1C);
        check_output("t1_done_cycle", done_rel, 32);
`ifdef SWU_FETCH_CKSUM_EN
        check_output("t1_cksum", done_cksum, 32'h1C1C1C1C);
`else
        check_output("t1_cksum", done_cksum, 32'h0);
`endif

        $display("[TB] backpressure stall");
        run_test(1, -1, -1, -1, -1);
        $display("[TB] toggling ready");
        run_test(2, -1, -1, -1, -1);
        $display("[TB] abort then clean pass");
        run_test(0, 10, -1, -1, -1);
        run_test(0, -1, -1, -1, -1);
        check_output("t4_first_valid", first_valid, 3);
        $display("[TB] stray starts and mid-pass reset");
        run_test(0, -1, -1, 5, 20);
        check_output("t5_done_cycle", done_rel, 32);
        run_test(0, -1, 12, -1, -1);

        $display("[TB] randomized passes");
        for (int p = 0; p < 20; p++) begin
            salt = $urandom;
            if ($urandom_range(0, 3) == 0)
                run_test(3, $urandom_range(2, 28), -1, -1, -1);
            else
                run_test(3, -1, -1, $urandom_range(2, 30), $urandom_range(2, 30));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
